wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Write-back stage plus architectural register file of the 5-stage MIPS pipeline.
- Consumes the MEM/WB pipeline register outputs: read data, write-back control, ALU result and destination register.
- Selects the write-back value and commits it to a 32x32 register file.
- Serves the two decode-stage read ports with same-cycle write-through bypass, and exports the write-back bus to the forwarding unit.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- ReadData  input  DATA_W  memory load data from MEM/WB
- WB  input  2  write-back control: WB[1]=RegWrite, WB[0]=MemToReg
- AluResult  input  DATA_W  ALU result from MEM/WB
- Mux  input  ADDR_W  destination register index from MEM/WB
- rs_addr  input  ADDR_W  decode read port A index
- rt_addr  input  ADDR_W  decode read port B index
- rs_data  output  DATA_W  read port A data
- rt_data  output  DATA_W  read port B data
- wb_data  output  DATA_W  selected write-back value, to forwarding unit
- wb_addr  output  ADDR_W  write-back destination, to forwarding unit
- wb_we  output  1  effective write enable, to forwarding unit
- wr_count  output  32  number of committed register writes

Behaviour:
- Reset and clocking:
  - One clock (clk); reset is synchronous and active-high (rst).
  - With rst high at a rising edge, all 32 registers clear to 0 and wr_count clears to 0.
  - No write commits in a reset cycle.
- Write-back select (combinational):
  - wb_data = ReadData when WB[0]=1, otherwise AluResult.
  - wb_addr = Mux.
  - wb_we = WB[1] and (Mux != 0) and not rst.
- Commit:
  - At a rising edge with wb_we=1, reg[Mux] <= wb_data and wr_count <= wr_count+1.
  - wr_count wraps from 0xFFFFFFFF to 0 with no flag.
- Register 0:
  - Always reads 0.
  - Writes to index 0 are discarded, do not assert wb_we and do not count.
- Read ports (combinational, zero latency):
  - rs_data = 0 if rs_addr=0.
  - Otherwise rs_data = wb_data if wb_we=1 and rs_addr=Mux (write-through bypass).
  - Otherwise rs_data = reg[rs_addr]. rt_data follows the same rule.
- Simultaneous events:
  - Both read ports may hit the write address in the same cycle; both are bypassed.
  - During rst=1, bypass is suppressed (wb_we=0), so reads return stored contents.
  - Stored contents read as 0 from the first edge of reset onward.
- Reset mid-operation: a write presented in the same cycle as rst is lost; it is not deferred.
- No stalls or back-pressure. A valid write-back is indicated solely by WB[1]; bubbles arrive as WB=0.
- All outputs are defined from time 0 after the first reset edge.
- Before the first reset, register contents are undefined; the bench must reset first.

Decomposition:
- Shared pipeline package holds:
  - constants WB_REGWRITE_BIT=1 and WB_MEMTOREG_BIT=0;
  - DATA_W and ADDR_W defaults;
  - the REG_ZERO=0 index constant;
  - a typedef for the 2-bit WB control field.
- One natural sub-module: regfile_2r1w. It holds the storage array, reset clear, write port, two read ports, zero register and bypass.
- The top level holds the write-back mux, the wb_we qualification and wr_count.

Test Plan:
- Reset then read all 32 indices on both ports -> every rs_data/rt_data = 0, wr_count=0.
- WB=2'b10, AluResult=0x0000_1234, Mux=5, rs_addr=5 in the same cycle -> rs_data=0x1234 (bypass), wb_we=1. The next cycle with WB=0 -> rs_data=0x1234 from storage, wr_count=1.
- WB=2'b11, ReadData=0xDEAD_BEEF, AluResult=0x1111_1111, Mux=31 -> wb_data=0xDEADBEEF. After the edge, rt_addr=31 reads 0xDEADBEEF.
- WB=2'b10, Mux=0, AluResult=0xFFFF_FFFF -> wb_we=0, reads of index 0 = 0, wr_count unchanged.
- Write 0xA5A5_A5A5 to reg 7, then assert rst together with WB=2'b10, Mux=7, AluResult=0x5555_5555 -> after the edge reg 7 = 0 and wr_count=0; during the reset cycle rs_addr=7 returns the stored 0xA5A5A5A5, not the bypass value.
- Force wr_count to 0xFFFF_FFFF (via 2^32-1 writes or a bench backdoor), then issue one valid write -> wr_count=0 and the register is written.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared pipeline definitions for the MIPS write-back stage: WB control field layout,
// default widths and the hard-wired zero register index.
package wb_regfile_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int ADDR_W_DEF      = 5;
    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;
    localparam int REG_ZERO        = 0;

    // Field order matches WB[1]=RegWrite, WB[0]=MemToReg.
    typedef struct packed {
        logic regwrite;
        logic memtoreg;
    } wb_ctrl_t;

endpackage

// File: rtl/wb_regfile_2r1w.sv
// 2-read / 1-write architectural register file with hard-wired zero register and
// same-cycle write-through bypass on both read ports.
module regfile_2r1w
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != ADDR_W'(REG_ZERO))) begin
            mem[waddr] <= wdata;
        end
    end

    // Zero register wins over bypass; bypass wins over storage.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] raddr,
        input logic              bypass_we,
        input logic [ADDR_W-1:0] bypass_addr,
        input logic [DATA_W-1:0] bypass_data,
        input logic [DATA_W-1:0] stored
    );
        if (raddr == ADDR_W'(REG_ZERO)) begin
            return '0;
        end else if (bypass_we && (raddr == bypass_addr)) begin
            return bypass_data;
        end else begin
            return stored;
        end
    endfunction

    always_comb begin
        rdata_a = read_port(raddr_a, we, waddr, wdata, mem[raddr_a]);
        rdata_b = read_port(raddr_b, we, waddr, wdata, mem[raddr_b]);
    end

endmodule

// File: rtl/wb_regfile.sv
// MIPS write-back stage: selects load data or ALU result, qualifies the write enable,
// commits into the register file and counts committed writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ReadData,
    input  logic [1:0]        WB,
    input  logic [DATA_W-1:0] AluResult,
    input  logic [ADDR_W-1:0] Mux,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              wb_we,
    output logic [31:0]       wr_count
);

    wb_ctrl_t wb_ctrl;

    always_comb begin
        wb_ctrl = wb_ctrl_t'(WB);
        wb_data = wb_ctrl.memtoreg ? ReadData : AluResult;
        wb_addr = Mux;
        // Writes to r0 and writes during reset are dropped, not deferred.
        wb_we   = wb_ctrl.regwrite && (Mux != ADDR_W'(REG_ZERO)) && !rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count <= '0;
        end else if (wb_we) begin
            wr_count <= wr_count + 32'd1;
        end
    end

    regfile_2r1w #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data),
        .raddr_a (rs_addr),
        .raddr_b (rt_addr),
        .rdata_a (rs_data),
        .rdata_b (rt_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset clear, write-back select, bypass, r0 handling,
// reset-during-write and write counter wrap.
`timescale 1ns/1ps
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ReadData;
    logic [1:0]  WB;
    logic [31:0] AluResult;
    logic [4:0]  Mux;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_we;
    logic [31:0] wr_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .ReadData  (ReadData),
        .WB        (WB),
        .AluResult (AluResult),
        .Mux       (Mux),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .wb_data   (wb_data),
        .wb_addr   (wb_addr),
        .wb_we     (wb_we),
        .wr_count  (wr_count)
    );

    task automatic idle();
        WB        = 2'b00;
        ReadData  = 32'h0;
        AluResult = 32'h0;
        Mux       = 5'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs_addr = 5'(i);
            rt_addr = 5'(31 - i);
            #1;
            n_cmp++;
            if (rs_data !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_rs[%0d]: got %h want 00000000", i, rs_data);
            end
            n_cmp++;
            if (rt_data !== 32'h0) begin
                n_bad++;
                $display("FAIL reset_rt[%0d]: got %h want 00000000", 31 - i, rt_data);
            end
        end
        n_cmp++;
        if (wr_count !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d want 0", wr_count);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        WB = 2'b10; AluResult = 32'h0000_1234; ReadData = 32'hCAFE_0000; Mux = 5'd5;
        rs_addr = 5'd5; rt_addr = 5'd6;
        #1;
        n_cmp++;
        if (rs_data !== 32'h0000_1234) begin
            n_bad++;
            $display("FAIL bypass_rs: got %h want 00001234", rs_data);
        end
        n_cmp++;
        if (wb_we !== 1'b1) begin
            n_bad++;
            $display("FAIL bypass_we: got %b want 1", wb_we);
        end
        n_cmp++;
        if (rt_data !== 32'h0) begin
            n_bad++;
            $display("FAIL bypass_rt_other: got %h want 00000000", rt_data);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (rs_data !== 32'h0000_1234) begin
            n_bad++;
            $display("FAIL stored_r5: got %h want 00001234", rs_data);
        end
        n_cmp++;
        if (wr_count !== 32'd1) begin
            n_bad++;
            $display("FAIL count_after_r5: got %0d want 1", wr_count);
        end
    endtask

    task automatic test_memtoreg();
        @(negedge clk);
        WB = 2'b11; ReadData = 32'hDEAD_BEEF; AluResult = 32'h1111_1111; Mux = 5'd31;
        #1;
        n_cmp++;
        if (wb_data !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL memtoreg_wb_data: got %h want deadbeef", wb_data);
        end
        n_cmp++;
        if (wb_addr !== 5'd31) begin
            n_bad++;
            $display("FAIL memtoreg_wb_addr: got %0d want 31", wb_addr);
        end
        @(posedge clk);
        @(negedge clk);
        WB = 2'b01; ReadData = 32'h7777_0000; AluResult = 32'h0000_8888; Mux = 5'd31;
        rt_addr = 5'd31;
        #1;
        n_cmp++;
        if (rt_data !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL stored_r31: got %h want deadbeef", rt_data);
        end
        n_cmp++;
        if (wb_we !== 1'b0 || wb_data !== 32'h7777_0000) begin
            n_bad++;
            $display("FAIL nowrite_select: got we=%b data=%h want we=0 data=77770000", wb_we, wb_data);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (wr_count !== 32'd2 || rt_data !== 32'hDEAD_BEEF) begin
            n_bad++;
            $display("FAIL count_after_r31: got cnt=%0d r31=%h want cnt=2 r31=deadbeef", wr_count, rt_data);
        end
    endtask

    task automatic test_zero_write();
        @(negedge clk);
        WB = 2'b10; AluResult = 32'hFFFF_FFFF; Mux = 5'd0;
        rs_addr = 5'd0; rt_addr = 5'd0;
        #1;
        n_cmp++;
        if (wb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL r0_we: got %b want 0", wb_we);
        end
        n_cmp++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            n_bad++;
            $display("FAIL r0_bypass: got rs=%h rt=%h want 0", rs_data, rt_data);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        #1;
        n_cmp++;
        if (rs_data !== 32'h0 || wr_count !== 32'd2) begin
            n_bad++;
            $display("FAIL r0_after: got r0=%h cnt=%0d want r0=0 cnt=2", rs_data, wr_count);
        end
    endtask

    task automatic test_back_to_back();
        // Consecutive writes; both ports hit the in-flight write in the second cycle.
        @(negedge clk);
        WB = 2'b10; AluResult = 32'h0000_0011; Mux = 5'd3;
        @(posedge clk);
        @(negedge clk);
        WB = 2'b11; ReadData = 32'h0000_0022; AluResult = 32'h0; Mux = 5'd4;
        rs_addr = 5'd4; rt_addr = 5'd4;
        #1;
        n_cmp++;
        if (rs_data !== 32'h22 || rt_data !== 32'h22) begin
            n_bad++;
            $display("FAIL dual_bypass: got rs=%h rt=%h want 00000022", rs_data, rt_data);
        end
        @(posedge clk);
        @(negedge clk);
        idle();
        rs_addr = 5'd3; rt_addr = 5'd4;
        #1;
        n_cmp++;
        if (rs_data !== 32'h11 || rt_data !== 32'h22) begin
            n_bad++;
            $display("FAIL b2b_stored: got r3=%h r4=%h want 11/22", rs_data, rt_data);
        end
        n_cmp++;
        if (wr_count !== 32'd4) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 4", wr_count);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        WB = 2'b10; AluResult = 32'hA5A5_A5A5; Mux = 5'd7;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        WB = 2'b10; AluResult = 32'h5555_5555; Mux = 5'd7;
        rs_addr = 5'd7;
        #1;
        n_cmp++;
        if (rs_data !== 32'hA5A5_A5A5) begin
            n_bad++;
            $display("FAIL rst_no_bypass: got %h want a5a5a5a5", rs_data);
        end
        n_cmp++;
        if (wb_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_we: got %b want 0", wb_we);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        rt_addr = 5'd31;
        #1;
        n_cmp++;
        if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
            n_bad++;
            $display("FAIL rst_cleared: got r7=%h r31=%h want 0", rs_data, rt_data);
        end
        n_cmp++;
        if (wr_count !== 32'd0) begin
            n_bad++;
            $display("FAIL rst_count: got %0d want 0", wr_count);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count;
        #1;
        n_cmp++;
        if (wr_count !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL wrap_preload: got %h want ffffffff", wr_count);
        end
        WB = 2'b10; AluResult = 32'h0000_0099; Mux = 5'd9;
        @(posedge clk);
        @(negedge clk);
        idle();
        rs_addr = 5'd9;
        #1;
        n_cmp++;
        if (wr_count !== 32'd0) begin
            n_bad++;
            $display("FAIL wrap_count: got %h want 00000000", wr_count);
        end
        n_cmp++;
        if (rs_data !== 32'h0000_0099) begin
            n_bad++;
            $display("FAIL wrap_write: got %h want 00000099", rs_data);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rs_addr = 5'd0;
        rt_addr = 5'd0;
        test_reset();
        test_bypass();
        test_memtoreg();
        test_zero_write();
        test_back_to_back();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
